// File: rtl/hdmi_timing_pkg.sv
// hdmi_timing_pkg: default 640x480@60 timing, colour-bar constants and FSM state encodings
package hdmi_timing_pkg;
    typedef logic [23:0] rgb_t;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF = 33;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN = 1'b1;
    localparam rgb_t GREY = 24'h808080;
    // Element 0 is the leftmost bar
    localparam logic [7:0][23:0] BARS = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };
endpackage

// File: rtl/hdmi_colour_bars.sv
// hdmi_colour_bars: combinational 8-bar colour lookup from h_cnt; exists only with TEST_PATTERN_EN
`ifdef TEST_PATTERN_EN
module hdmi_colour_bars
    import hdmi_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF
) (
    input  logic [10:0] h_cnt,
    output rgb_t        colour
);
    localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);
    logic [10:0] q;
    always_comb begin
        q = h_cnt / BAR_W;
        colour = BARS[q > 11'd7 ? 3'd7 : q[2:0]];
    end
endmodule
`endif

// File: rtl/hdmi_video_timing.sv
// hdmi_video_timing: IDLE/RUN raster generator driving registered RGB/de/hs/vs/frame_start.
// Define TEST_PATTERN_EN for colour bars; otherwise active pixels are constant grey.
module hdmi_video_timing
    import hdmi_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP = H_FP_DEF,
    parameter int H_SYNC = H_SYNC_DEF,
    parameter int H_BP = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP = V_FP_DEF,
    parameter int V_SYNC = V_SYNC_DEF,
    parameter int V_BP = V_BP_DEF,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic [23:0] hdmi_tx_d,
    output logic        hdmi_tx_de,
    output logic        hdmi_tx_hs,
    output logic        hdmi_tx_vs,
    output logic        frame_start
);
    localparam logic [10:0] HA = 11'(H_ACTIVE);
    localparam logic [10:0] HS0 = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS1 = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] HL = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] VA = 11'(V_ACTIVE);
    localparam logic [10:0] VS0 = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS1 = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] VL = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    logic [0:0] state;
    logic [10:0] h_cnt, v_cnt;
    rgb_t pix;
    logic run, act, h_sync, v_sync;
    always_comb begin
        run = state == RUN;
        act = h_cnt < HA && v_cnt < VA;
        h_sync = h_cnt >= HS0 && h_cnt < HS1;
        v_sync = v_cnt >= VS0 && v_cnt < VS1;
    end
`ifdef TEST_PATTERN_EN
    hdmi_colour_bars #(.H_ACTIVE(H_ACTIVE)) u_bars (.h_cnt(h_cnt), .colour(pix));
`else
    assign pix = GREY;
`endif
    // Outputs are decoded from the counters of the previous cycle, so all stay aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
            hdmi_tx_d <= '0;
            hdmi_tx_de <= 1'b0;
            hdmi_tx_hs <= ~SYNC_POL;
            hdmi_tx_vs <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            state <= enable ? RUN : IDLE;
            h_cnt <= !run || h_cnt == HL ? 11'd0 : h_cnt + 11'd1;
            v_cnt <= !run ? 11'd0 : h_cnt != HL ? v_cnt : v_cnt == VL ? 11'd0 : v_cnt + 11'd1;
            hdmi_tx_d <= run && act ? pix : '0;
            hdmi_tx_de <= run && act;
            hdmi_tx_hs <= run && h_sync ? SYNC_POL : ~SYNC_POL;
            hdmi_tx_vs <= run && v_sync ? SYNC_POL : ~SYNC_POL;
            frame_start <= run && h_cnt == 11'd0 && v_cnt == 11'd0;
        end
    end
endmodule

// File: tb/tb_hdmi_video_timing.sv
// tb_hdmi_video_timing: randomized scoreboard bench with a raster-arithmetic reference model.
// Default horizontal timing; vertical timing shortened so several frames fit in the run.
module tb_hdmi_video_timing;
    localparam int HA = 640, HF = 16, HS = 96, HB = 48;
    localparam int VA = 12, VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    typedef struct packed {
        logic [23:0] d;
        logic de, hs, vs, fs;
    } out_t;

    logic clk = 1'b0, rst = 1'b1, enable = 1'b0;
    logic [23:0] hdmi_tx_d;
    logic hdmi_tx_de, hdmi_tx_hs, hdmi_tx_vs, frame_start;
    out_t q[$];
    int n_chk = 0, n_fail = 0, streak = 0;
    bit meas = 1'b0;

    hdmi_video_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .hdmi_tx_d(hdmi_tx_d),
        .hdmi_tx_de(hdmi_tx_de), .hdmi_tx_hs(hdmi_tx_hs), .hdmi_tx_vs(hdmi_tx_vs),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] colour(input int x);
`ifdef TEST_PATTERN_EN
        case (x / (HA / 8))
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
`else
        return 24'h808080;
`endif
    endfunction

    // Pixel t of an uninterrupted run, counted from the first pixel of a frame
    function automatic out_t pixel(input int t);
        int x, y;
        out_t o;
        x = t % HT;
        y = (t / HT) % VT;
        o.de = x < HA && y < VA;
        o.d = o.de ? colour(x) : 24'h0;
        o.hs = !(x >= HA + HF && x < HA + HF + HS);
        o.vs = !(y >= VA + VF && y < VA + VF + VS);
        o.fs = x == 0 && y == 0;
        return o;
    endfunction

    // An edge outputs pixel n-1 after n consecutive earlier edges saw enable without reset
    task automatic step(input bit r, input bit e);
        out_t o;
        @(negedge clk);
        rst = r;
        enable = e;
        o = (r || streak == 0) ? out_t'({24'h0, 1'b0, 1'b1, 1'b1, 1'b0}) : pixel(streak - 1);
        q.push_back(o);
        streak = (!r && e) ? streak + 1 : 0;
    endtask

    initial begin
        int cyc = 0, lhf = -1, ldr = -1, lvf = -1, lfs = -1, lines = -1;
        logic p_hs = 1'b1, p_de = 1'b0, p_vs = 1'b1;
        out_t e;
        @(negedge clk);
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() == 0) cmp("sb_underflow", 0, 1);
            else begin
                e = q.pop_front();
                cmp("d", int'(hdmi_tx_d), int'(e.d));
                cmp("de", int'(hdmi_tx_de), int'(e.de));
                cmp("hs", int'(hdmi_tx_hs), int'(e.hs));
                cmp("vs", int'(hdmi_tx_vs), int'(e.vs));
                cmp("frame_start", int'(frame_start), int'(e.fs));
            end
            if (!meas) begin
                lhf = -1; ldr = -1; lvf = -1; lfs = -1; lines = -1;
            end else begin
                if (p_hs && !hdmi_tx_hs) begin
                    if (lhf >= 0) cmp("hs_period", cyc - lhf, HT);
                    if (ldr >= 0 && cyc - ldr < HT) cmp("hs_after_de", cyc - ldr, HA + HF);
                    lhf = cyc;
                end
                if (!p_hs && hdmi_tx_hs && lhf >= 0) cmp("hs_width", cyc - lhf, HS);
                if (frame_start) begin
                    if (lfs >= 0) cmp("fs_period", cyc - lfs, HT * VT);
                    if (lines >= 0) cmp("de_lines", lines, VA);
                    lfs = cyc;
                    lines = 0;
                end
                if (!p_de && hdmi_tx_de) begin
                    ldr = cyc;
                    if (lines >= 0) lines++;
                end
                if (p_de && !hdmi_tx_de && ldr >= 0) cmp("de_len", cyc - ldr, HA);
                if (p_vs && !hdmi_tx_vs) lvf = cyc;
                if (!p_vs && hdmi_tx_vs && lvf >= 0) cmp("vs_width", cyc - lvf, VS * HT);
            end
            p_hs = hdmi_tx_hs;
            p_de = hdmi_tx_de;
            p_vs = hdmi_tx_vs;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(0, 1)));
        for (int i = 0; i < int'($urandom_range(2, 6)); i++) step(1'b0, 1'b0);
        meas = 1'b1;
        for (int i = 0; i < 2 * HT * VT + 50; i++) step(1'b0, 1'b1);
        meas = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        meas = 1'b1;
        while (streak != 10 * HT + 700) step(1'b0, 1'b1);
        meas = 1'b0;
        for (int i = 0; i < int'($urandom_range(1, 4)); i++) step(1'b0, 1'b0);
        for (int i = 0; i < 3 * HT; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 200; i++) step(1'b0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 700; i++) step(1'b0, 1'b1);
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) step(1'b1, 1'b1);
        for (int i = 0; i < 2 * HT; i++) step(1'b0, 1'b1);
        @(posedge clk);
        #2;
        cmp("sb_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hdmi_video_timing.md
HDMI_VIDEO_TIMING -- requirements
Module: hdmi_video_timing

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, meaning active pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16, meaning horizontal front porch in pixel clocks.
REQ-003 The block SHALL have parameter H_SYNC, default 96, meaning horizontal sync width in pixel clocks.
REQ-004 The block SHALL have parameter H_BP, default 48, meaning horizontal back porch in pixel clocks.
REQ-005 The block SHALL have parameters V_ACTIVE, V_FP, V_SYNC and V_BP, defaults 480, 10, 2 and 33, meaning the vertical equivalents of REQ-001 to REQ-004, counted in lines.
REQ-006 The block SHALL have parameter SYNC_POL, default 0, meaning the asserted level of hs and vs.
REQ-007 The block SHALL have port clk, input, 1 bit: the pixel clock, on which all logic runs.
REQ-008 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 The block SHALL have port enable, input, 1 bit: video run request, driven high when HDMI configuration is complete.
REQ-010 The block SHALL have port hdmi_tx_d, output, 24 bits: RGB pixel data, R in [23:16], G in [15:8], B in [7:0].
REQ-011 The block SHALL have ports hdmi_tx_de, hdmi_tx_hs and hdmi_tx_vs, outputs, 1 bit each: data enable, horizontal sync and vertical sync.
REQ-012 The block SHALL have port frame_start, output, 1 bit: one-cycle pulse at the first active pixel of each frame.

Function
REQ-013 The block SHALL keep 11-bit counters h_cnt (0 to H_TOTAL-1) and v_cnt (0 to V_TOTAL-1), where H_TOTAL is the sum of the four H parameters and V_TOTAL is the sum of the four V parameters.
REQ-014 h_cnt SHALL increment every cycle in RUN and wrap to 0 after H_TOTAL-1.
REQ-015 v_cnt SHALL increment only when h_cnt wraps, and SHALL itself wrap to 0 after V_TOTAL-1.
REQ-016 Region order SHALL be active, then front porch, then sync, then back porch; active spans h_cnt 0 to H_ACTIVE-1, and sync spans h_cnt H_ACTIVE+H_FP to H_ACTIVE+H_FP+H_SYNC-1 (vertical regions analogous).
REQ-017 de SHALL be high only when both h_cnt and v_cnt are in their active regions.
REQ-018 hs SHALL equal SYNC_POL during the horizontal sync region and the inverse of SYNC_POL elsewhere.
REQ-019 vs SHALL equal SYNC_POL during the vertical sync region for full lines and the inverse of SYNC_POL elsewhere.
REQ-020 All outputs SHALL be registered with exactly one cycle of latency from counter state, so d, de, hs and vs stay mutually aligned.
REQ-021 The FSM SHALL have two states, IDLE and RUN.
REQ-022 In IDLE, the FSM SHALL move to RUN when enable is high, with counters at 0/0.
REQ-023 In RUN, the FSM SHALL move to IDLE when enable is low.
REQ-024 In IDLE, the counters SHALL be held at 0, de SHALL be 0, hs and vs SHALL be inactive, d SHALL be 0 and frame_start SHALL be 0.
REQ-025 If enable drops mid-frame, the block SHALL return to IDLE on the next cycle, with outputs inactive the cycle after.
REQ-026 A later rise of enable SHALL restart the frame at h_cnt=0, v_cnt=0.
REQ-027 frame_start SHALL assert with the output for h_cnt=0, v_cnt=0, and SHALL be 0 otherwise.
REQ-028 When de is 0, d SHALL be 24'h000000.

Reset
REQ-029 rst SHALL take priority over enable and SHALL force IDLE and counters to 0.
REQ-030 While rst is high, outputs SHALL be d=0, de=0, frame_start=0, and hs=vs=~SYNC_POL.
REQ-031 Assertion of rst mid-line SHALL take effect on the next clk edge, with no partial sync pulse afterwards.

Configuration
REQ-032 With TEST_PATTERN_EN defined, active d SHALL show 8 equal vertical bars of width H_ACTIVE/8, in this order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
REQ-033 With TEST_PATTERN_EN undefined, active d SHALL be constant 24'h808080, and the bar logic SHALL be absent.

Structure
REQ-034 Default timing constants, the colour-bar constants and the FSM state encodings SHALL reside in shared package hdmi_timing_pkg.
REQ-035 The bar colour lookup SHALL be the single sub-module hdmi_colour_bars, which takes h_cnt and returns 24-bit colour, combinational; it SHALL be instantiated only under TEST_PATTERN_EN.

Verification
REQ-036 Reset: with rst=1 for 5 cycles, the bench SHALL check d=0, de=0, hs=1, vs=1 and frame_start=0 with defaults.
REQ-037 Line timing: with enable=1, the bench SHALL check that hs falling edges are 800 cycles apart, that each hs low pulse is 96 cycles, and that it starts 656 cycles after de rise.
REQ-038 Frame timing: the bench SHALL check 640 de cycles per line, 480 de lines per frame, a vs low pulse of 2 lines (1600 cycles), and frame_start every 420000 cycles.
REQ-039 Pattern (TEST_PATTERN_EN): the bench SHALL check d=FFFFFF at x=0, FFFF00 at x=80, FF0000 at x=400 and 000000 at x=639.
REQ-040 Pattern (TEST_PATTERN_EN undefined): the bench SHALL check d=808080 at every active pixel.
REQ-041 Enable drop: the bench SHALL drop enable at v_cnt=100 and check de=0 and hs=vs=1 within 2 cycles; it SHALL then re-raise enable and check frame_start after 1 cycle.
